aes_bus_driver: RTL and testbench
=================================

Name: aes_bus_driver

Overview:
- Host-side initiator for the 32-bit word-addressed AES wrapper bus.
- Takes a 256-bit key and a 128-bit block from a host, and serializes them into indexed 32-bit writes:
  - select 0-7 carries key words;
  - select 8-b carries data words.
- Waits for key expansion and result-valid, then reads the four result words back through the 2-bit output select.
- Presents the result to the host as one 128-bit block.
- Sits between a host/DMA engine and the AES bus wrapper. One block in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles waited in KEY_WAIT or RESULT_WAIT before aborting.
- TMO_W, 13: timeout counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- i_key  in  256  key; word n = i_key[32n+31:32n]
- i_key_mode  in  2  key size code, passed through to the bus
- i_key_load  in  1  key load request; accepted only when o_host_ready=1
- i_block  in  128  input block; word n = i_block[32n+31:32n]
- i_enc_dec  in  1  1=encrypt, 0=decrypt; sampled when the block is accepted
- i_block_valid  in  1  block request; accepted only when o_host_ready=1 and a key is loaded
- o_host_ready  out  1  1 iff FSM is in IDLE
- o_key_loaded  out  1  key expansion completed and still valid
- o_block  out  128  result block
- o_block_valid  out  1  1-cycle pulse; o_block valid
- o_error  out  1  1-cycle pulse on timeout or on a rejected block request
- bus_enable  out  1  core enable
- bus_enc_dec  out  1  direction to the wrapper
- bus_key_mode  out  2  key mode to the wrapper
- bus_data  out  32  write word
- bus_data_sel  out  4  write word index
- bus_data_valid  out  1  write strobe
- bus_o_data_sel  out  2  read word index
- bus_o_data  in  32  read word; registered in the wrapper, valid 1 cycle after select
- bus_key_ready  in  1  key expansion done
- bus_ready  in  1  core can accept data
- bus_o_data_valid  in  1  result-valid pulse from the core

Behaviour:
- Reset values (reset=0):
  - all outputs 0 except o_host_ready=1;
  - bus_enable goes to 1 the first clk after reset release and stays 1;
  - FSM is in IDLE, key-loaded flag cleared, counters 0.
- Reset asserted mid-operation aborts immediately with no completion pulse, and the key must be reloaded.
- All bus_* outputs are registered.
- IDLE:
  - i_key_load=1: latch i_key and i_key_mode, clear key-loaded, go to KEY_WR.
  - Else i_block_valid=1 and key-loaded=1: latch i_block and i_enc_dec, go to DATA_WAIT.
  - Else i_block_valid=1 and key-loaded=0: pulse o_error, stay in IDLE.
  - Key load and block valid in the same cycle: key wins and the block is dropped (host must re-present it).
- KEY_WR: 8 cycles with bus_data_valid=1 and bus_data_sel=0,1,...,7 carrying key words 0-7 in order. The cycle after sel=7, go to KEY_WAIT.
- KEY_WAIT:
  - bus_key_ready=1: set key-loaded, go to IDLE.
  - Timeout counter reaches TIMEOUT_CYCLES: pulse o_error, go to IDLE.
  - bus_key_ready sampled in the first cycle of KEY_WAIT is ignored (stale from a previous key).
- DATA_WAIT: when bus_ready=1, go to DATA_WR. Timeout rule as in KEY_WAIT.
- DATA_WR:
  - 4 cycles, bus_data_sel=8,9,a,b carrying block words 0-3; bus_enc_dec is stable throughout.
  - Then bus_data_valid=0, go to RESULT_WAIT.
- RESULT_WAIT: on bus_o_data_valid=1, go to READ. Timeout rule as above.
- READ:
  - 5 cycles R0-R4. bus_o_data_sel=0,1,2,3,3.
  - At R(k+1), capture bus_o_data into result word k, for k=0..3.
  - Cycle after R4: o_block updated and o_block_valid=1 for 1 cycle, FSM in IDLE.
- o_block holds its value until the next completion.
- bus_data_valid is 0 whenever the FSM is outside KEY_WR/DATA_WR.
- Timeout counter clears on entry to every wait state.
- Any bus_o_data_valid outside RESULT_WAIT is ignored.
- Key/block inputs are only sampled at acceptance; later changes have no effect.
- Minimum latency, block accept to o_block_valid: 1 (DATA_WAIT, if bus_ready) + 4 + core latency + 5 + 1.

Decomposition:
- Package aes_bus_pkg:
  - state enum {IDLE, KEY_WR, KEY_WAIT, DATA_WAIT, DATA_WR, RESULT_WAIT, READ};
  - constants KEY_SEL_BASE=4'h0, DATA_SEL_BASE=4'h8, KEY_WORDS=8, DATA_WORDS=4.
- One sub-module, aes_bus_readback: drives the read select sequence, captures the 4 words with 1-cycle lag, emits the 128-bit block plus a done strobe.

Test Plan:
- Reset=0 mid-DATA_WR (after sel=9) -> bus_data_valid=0, o_host_ready=1, o_key_loaded=0, no o_block_valid; a new key load then succeeds normally.
- FIPS-197 AES-128:
  - key 000102030405060708090a0b0c0d0e0f (upper 128 bits 0), mode 0, encrypt, plaintext 00112233445566778899aabbccddeeff;
  - expect writes sel 0-7 then 8-b with word order as specified;
  - expect o_block=69c4e0d86a7b0430d8cdb78070b4c55a with one o_block_valid pulse.
- Same key, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a -> o_block=00112233445566778899aabbccddeeff, and no key rewrite (only sel 8-b writes).
- i_block_valid with no key loaded -> o_error pulse, zero bus writes. Key load and block valid in the same cycle -> only key writes occur.
- Model holds bus_key_ready=0 -> o_error pulse after exactly TIMEOUT_CYCLES KEY_WAIT cycles, FSM back in IDLE, o_key_loaded=0.
- Readback timing: model returns per-select words 11111111/22222222/33333333/44444444 for sel 0-3 with 1-cycle delay -> o_block=44444444333333332222222211111111.

Source files
------------

// File: rtl/aes_bus_pkg.sv
// Types and constants shared by the AES wrapper bus initiator and its readback unit.
package aes_bus_pkg;
  typedef enum logic [2:0] {
    IDLE,
    KEY_WR,
    KEY_WAIT,
    DATA_WAIT,
    DATA_WR,
    RESULT_WAIT,
    READ
  } state_e;

  localparam logic [3:0] KEY_SEL_BASE  = 4'h0;
  localparam logic [3:0] DATA_SEL_BASE = 4'h8;
  localparam int         KEY_WORDS     = 8;
  localparam int         DATA_WORDS    = 4;
endpackage

// File: rtl/aes_bus_readback.sv
// Walks the 2-bit output select 0,1,2,3,3 and captures each returned word one cycle
// after its select, then presents the assembled 128-bit block with a done strobe.
module aes_bus_readback
  import aes_bus_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [31:0]  i_rd_data,
  output logic [1:0]   o_rd_sel,
  output logic         o_last,
  output logic [127:0] o_block,
  output logic         o_done
);
  logic         r_active;
  logic [2:0]   r_cnt;
  logic [1:0]   r_sel;
  logic [95:0]  r_acc;
  logic [127:0] r_block;
  logic         r_done;
  logic [2:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 3'd1;
  assign o_last    = r_active && (r_cnt == 3'(DATA_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_acc    <= '0;
      r_block  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_sel    <= '0;
      end else if (r_active) begin
        r_cnt <= w_cnt_inc;
        // the last select is held for one extra cycle so word 3 lands in R4
        r_sel <= (r_cnt >= 3'(DATA_WORDS - 1)) ? 2'(DATA_WORDS - 1) : w_cnt_inc[1:0];
        case (r_cnt)
          3'd1:    r_acc[31:0]  <= i_rd_data;
          3'd2:    r_acc[63:32] <= i_rd_data;
          3'd3:    r_acc[95:64] <= i_rd_data;
          default: ;
        endcase
        if (o_last) begin
          r_active <= 1'b0;
          r_sel    <= '0;
          r_block  <= {i_rd_data, r_acc};
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_rd_sel = r_sel;
  assign o_block  = r_block;
  assign o_done   = r_done;
endmodule

// File: rtl/aes_bus_driver.sv
// Host-side initiator: writes key/data words to the AES wrapper, waits, reads the result.
//   state       | meaning
//   IDLE        | host ready; accepts key load or block
//   KEY_WR      | writing key words sel 0-7
//   KEY_WAIT    | waiting for key expansion (first cycle's key_ready ignored)
//   DATA_WAIT   | waiting for core ready
//   DATA_WR     | writing data words sel 8-b
//   RESULT_WAIT | waiting for result-valid pulse
//   READ        | readback unit collecting the four result words
module aes_bus_driver
  import aes_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W          = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_key_mode,
  input  logic         i_key_load,
  input  logic [127:0] i_block,
  input  logic         i_enc_dec,
  input  logic         i_block_valid,
  output logic         o_host_ready,
  output logic         o_key_loaded,
  output logic [127:0] o_block,
  output logic         o_block_valid,
  output logic         o_error,
  output logic         bus_enable,
  output logic         bus_enc_dec,
  output logic [1:0]   bus_key_mode,
  output logic [31:0]  bus_data,
  output logic [3:0]   bus_data_sel,
  output logic         bus_data_valid,
  output logic [1:0]   bus_o_data_sel,
  input  logic [31:0]  bus_o_data,
  input  logic         bus_key_ready,
  input  logic         bus_ready,
  input  logic         bus_o_data_valid
);
  state_e           r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt, w_idx_inc;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             r_key_loaded, w_key_loaded_nxt;
  logic             r_error, w_error_nxt;
  logic [255:0]     r_key;
  logic [127:0]     r_block;
  logic             w_latch_key, w_latch_blk, w_rb_start, w_rb_last, w_timeout;
  logic             w_dv_nxt;
  logic [3:0]       w_sel_nxt;
  logic [31:0]      w_data_nxt;
  logic             r_bus_enable, r_bus_enc_dec, r_bus_data_valid;
  logic [1:0]       r_bus_key_mode;
  logic [31:0]      r_bus_data;
  logic [3:0]       r_bus_data_sel;

  assign w_idx_inc = r_idx + 3'd1;
  assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // bus write strobe/select/data are computed one cycle early so the registered outputs line up with the state
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_tmo_nxt        = '0;
    w_key_loaded_nxt = r_key_loaded;
    w_error_nxt      = 1'b0;
    w_latch_key      = 1'b0;
    w_latch_blk      = 1'b0;
    w_rb_start       = 1'b0;
    w_dv_nxt         = 1'b0;
    w_sel_nxt        = r_bus_data_sel;
    w_data_nxt       = r_bus_data;
    unique case (r_state)
      IDLE: begin
        if (i_key_load) begin
          w_latch_key      = 1'b1;
          w_key_loaded_nxt = 1'b0;
          w_state_nxt      = KEY_WR;
          w_idx_nxt        = '0;
          w_dv_nxt         = 1'b1;
          w_sel_nxt        = KEY_SEL_BASE;
          w_data_nxt       = i_key[31:0];
        end else if (i_block_valid) begin
          if (r_key_loaded) begin
            w_latch_blk = 1'b1;
            w_state_nxt = DATA_WAIT;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      KEY_WR: begin
        if (r_idx == 3'(KEY_WORDS - 1)) begin
          w_state_nxt = KEY_WAIT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt  = w_idx_inc;
          w_dv_nxt   = 1'b1;
          w_sel_nxt  = KEY_SEL_BASE + {1'b0, w_idx_inc};
          w_data_nxt = r_key[{w_idx_inc, 5'd0} +: 32];
        end
      end
      KEY_WAIT: begin
        if (bus_key_ready && (r_tmo != '0)) begin
          w_key_loaded_nxt = 1'b1;
          w_state_nxt      = IDLE;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      DATA_WAIT: begin
        if (bus_ready) begin
          w_state_nxt = DATA_WR;
          w_idx_nxt   = '0;
          w_dv_nxt    = 1'b1;
          w_sel_nxt   = DATA_SEL_BASE;
          w_data_nxt  = r_block[31:0];
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      DATA_WR: begin
        if (r_idx == 3'(DATA_WORDS - 1)) begin
          w_state_nxt = RESULT_WAIT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt  = w_idx_inc;
          w_dv_nxt   = 1'b1;
          w_sel_nxt  = DATA_SEL_BASE + {1'b0, w_idx_inc};
          w_data_nxt = r_block[{w_idx_inc[1:0], 5'd0} +: 32];
        end
      end
      RESULT_WAIT: begin
        if (bus_o_data_valid) begin
          w_state_nxt = READ;
          w_rb_start  = 1'b1;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      READ: begin
        if (w_rb_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx            <= '0;
      r_tmo            <= '0;
      r_key_loaded     <= 1'b0;
      r_error          <= 1'b0;
      r_key            <= '0;
      r_block          <= '0;
      r_bus_enable     <= 1'b0;
      r_bus_enc_dec    <= 1'b0;
      r_bus_key_mode   <= '0;
      r_bus_data       <= '0;
      r_bus_data_sel   <= '0;
      r_bus_data_valid <= 1'b0;
    end else begin
      r_idx            <= w_idx_nxt;
      r_tmo            <= w_tmo_nxt;
      r_key_loaded     <= w_key_loaded_nxt;
      r_error          <= w_error_nxt;
      r_bus_enable     <= 1'b1;
      r_bus_data       <= w_data_nxt;
      r_bus_data_sel   <= w_sel_nxt;
      r_bus_data_valid <= w_dv_nxt;
      if (w_latch_key) begin
        r_key          <= i_key;
        r_bus_key_mode <= i_key_mode;
      end
      if (w_latch_blk) begin
        r_block       <= i_block;
        r_bus_enc_dec <= i_enc_dec;
      end
    end
  end

  aes_bus_readback u_readback (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_rb_start),
    .i_rd_data (bus_o_data),
    .o_rd_sel  (bus_o_data_sel),
    .o_last    (w_rb_last),
    .o_block   (o_block),
    .o_done    (o_block_valid)
  );

  assign o_host_ready   = (r_state == IDLE);
  assign o_key_loaded   = r_key_loaded;
  assign o_error        = r_error;
  assign bus_enable     = r_bus_enable;
  assign bus_enc_dec    = r_bus_enc_dec;
  assign bus_key_mode   = r_bus_key_mode;
  assign bus_data       = r_bus_data;
  assign bus_data_sel   = r_bus_data_sel;
  assign bus_data_valid = r_bus_data_valid;
endmodule

// File: tb/tb_aes_bus_driver.sv
// Scoreboard bench for aes_bus_driver with a small behavioural AES wrapper model.
module tb_aes_bus_driver;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] i_key = '0;
  logic [1:0]   i_key_mode = '0;
  logic         i_key_load = 1'b0;
  logic [127:0] i_block = '0;
  logic         i_enc_dec = 1'b0;
  logic         i_block_valid = 1'b0;
  logic         o_host_ready, o_key_loaded, o_block_valid, o_error;
  logic [127:0] o_block;
  logic         bus_enable, bus_enc_dec, bus_data_valid;
  logic [1:0]   bus_key_mode, bus_o_data_sel;
  logic [31:0]  bus_data, bus_o_data;
  logic [3:0]   bus_data_sel;
  logic         bus_key_ready, bus_o_data_valid;
  logic         bus_ready = 1'b1;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] data;
    logic        chk_enc;
    logic        enc;
  } wr_t;

  wr_t          wq[$];
  logic [127:0] bq[$];
  int           eq[$];
  wr_t          mon_w;
  logic [127:0] mon_b;
  int           n_tests = 0;
  int           n_fail = 0;

  logic [127:0] model_result = '0;
  bit           model_key_ok = 1'b1;
  bit           stray_req = 1'b0;
  int           kcnt, rcnt;

  localparam logic [255:0] FIPS_KEY = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_bus_driver dut (
    .clk              (clk),
    .reset            (reset),
    .i_key            (i_key),
    .i_key_mode       (i_key_mode),
    .i_key_load       (i_key_load),
    .i_block          (i_block),
    .i_enc_dec        (i_enc_dec),
    .i_block_valid    (i_block_valid),
    .o_host_ready     (o_host_ready),
    .o_key_loaded     (o_key_loaded),
    .o_block          (o_block),
    .o_block_valid    (o_block_valid),
    .o_error          (o_error),
    .bus_enable       (bus_enable),
    .bus_enc_dec      (bus_enc_dec),
    .bus_key_mode     (bus_key_mode),
    .bus_data         (bus_data),
    .bus_data_sel     (bus_data_sel),
    .bus_data_valid   (bus_data_valid),
    .bus_o_data_sel   (bus_o_data_sel),
    .bus_o_data       (bus_o_data),
    .bus_key_ready    (bus_key_ready),
    .bus_ready        (bus_ready),
    .bus_o_data_valid (bus_o_data_valid)
  );

  always #5 clk = ~clk;

  // Wrapper model: registered readback, key_ready a few cycles after the key, result some cycles after word b.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_key_ready    <= 1'b0;
      bus_o_data_valid <= 1'b0;
      bus_o_data       <= '0;
      kcnt             <= 0;
      rcnt             <= 0;
    end else begin
      bus_o_data       <= model_result[{bus_o_data_sel, 5'd0} +: 32];
      bus_o_data_valid <= stray_req;
      if (bus_data_valid && bus_data_sel < 4'h8) begin
        bus_key_ready <= 1'b0;
        kcnt          <= 3;
      end else if (kcnt == 1) begin
        kcnt          <= 0;
        bus_key_ready <= model_key_ok;
      end else if (kcnt > 1) begin
        kcnt <= kcnt - 1;
      end
      if (bus_data_valid && bus_data_sel == 4'hb) begin
        rcnt <= 6;
      end else if (rcnt == 1) begin
        rcnt             <= 0;
        bus_o_data_valid <= 1'b1;
      end else if (rcnt > 1) begin
        rcnt <= rcnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected no event", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a result or an error.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_data_valid) begin
        if (wq.size() == 0) unexpected("bus_write", {bus_data_sel, bus_data});
        else begin
          mon_w = wq.pop_front();
          check("bus_data_sel", bus_data_sel, mon_w.sel);
          check("bus_data", bus_data, mon_w.data);
          if (mon_w.chk_enc) check("bus_enc_dec", bus_enc_dec, mon_w.enc);
        end
      end
      if (o_block_valid) begin
        if (bq.size() == 0) unexpected("o_block_valid", o_block);
        else begin
          mon_b = bq.pop_front();
          check("o_block", o_block, mon_b);
          check("ready_at_done", o_host_ready, 1'b1);
        end
      end
      if (o_error) begin
        if (eq.size() == 0) unexpected("o_error", 128'd1);
        else void'(eq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input logic [3:0] sel, input logic [31:0] data, input logic chk, input logic enc);
    wr_t w;
    w.sel = sel; w.data = data; w.chk_enc = chk; w.enc = enc;
    wq.push_back(w);
  endtask

  task automatic key_load(input logic [255:0] k, input logic [1:0] mode, input logic also_block);
    i_key = k; i_key_mode = mode; i_key_load = 1'b1; i_block_valid = also_block;
    tick(1);
    i_key_load = 1'b0; i_block_valid = 1'b0;
    i_key = ~k; i_key_mode = ~mode;
  endtask

  task automatic send_block(input logic [127:0] b, input logic enc);
    i_block = b; i_enc_dec = enc; i_block_valid = 1'b1;
    tick(1);
    i_block_valid = 1'b0;
    i_block = ~b; i_enc_dec = ~enc;
  endtask

  task automatic drain(input string name, input int lim);
    int n = 0;
    while ((wq.size() + bq.size() + eq.size()) != 0 && n < lim) begin
      tick(1);
      n++;
    end
    check(name, wq.size() + bq.size() + eq.size(), 0);
  endtask

  task automatic wait_loaded(input string name, input int lim);
    int n = 0;
    while (!o_key_loaded && n < lim) begin
      tick(1);
      n++;
    end
    check(name, o_key_loaded, 1'b1);
  endtask

  task automatic push_fips_key();
    push_wr(4'h0, 32'h0c0d0e0f, 1'b0, 1'b0);
    push_wr(4'h1, 32'h08090a0b, 1'b0, 1'b0);
    push_wr(4'h2, 32'h04050607, 1'b0, 1'b0);
    push_wr(4'h3, 32'h00010203, 1'b0, 1'b0);
    for (int i = 4; i < 8; i++) push_wr(4'(i), 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt, n;
    #1 reset = 1'b0;
    tick(1);
    check("rst_host_ready", o_host_ready, 1'b1);
    check("rst_outputs", {o_key_loaded, o_block_valid, o_error, bus_enable, bus_enc_dec,
                          bus_key_mode, bus_data_valid, bus_data_sel, bus_o_data_sel}, '0);
    check("rst_bus_data", bus_data, 32'h0);
    check("rst_o_block", o_block, 128'h0);
    reset = 1'b1;
    tick(1);
    check("bus_enable_after_rst", bus_enable, 1'b1);

    // block with no key loaded
    eq.push_back(1);
    send_block(FIPS_PT, 1'b1);
    tick(3);
    drain("nokey_err", 10);
    check("nokey_not_loaded", o_key_loaded, 1'b0);

    // FIPS-197 key, with a simultaneous block request that must be dropped
    push_fips_key();
    i_block = FIPS_PT;
    key_load(FIPS_KEY, 2'b00, 1'b1);
    drain("fips_key_writes", 40);
    wait_loaded("fips_key_loaded", 40);
    tick(3);

    model_result = FIPS_CT;
    push_wr(4'h8, 32'hccddeeff, 1'b1, 1'b1);
    push_wr(4'h9, 32'h8899aabb, 1'b1, 1'b1);
    push_wr(4'ha, 32'h44556677, 1'b1, 1'b1);
    push_wr(4'hb, 32'h00112233, 1'b1, 1'b1);
    bq.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    send_block(FIPS_PT, 1'b1);
    drain("fips_enc", 200);
    tick(4);
    check("o_block_hold", o_block, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    model_result = FIPS_PT;
    push_wr(4'h8, 32'h70b4c55a, 1'b1, 1'b0);
    push_wr(4'h9, 32'hd8cdb780, 1'b1, 1'b0);
    push_wr(4'ha, 32'h6a7b0430, 1'b1, 1'b0);
    push_wr(4'hb, 32'h69c4e0d8, 1'b1, 1'b0);
    bq.push_back(128'h00112233445566778899aabbccddeeff);
    send_block(FIPS_CT, 1'b0);
    drain("fips_dec", 200);
    tick(3);

    // stray result-valid while idle, then readback ordering with a stalled core
    stray_req = 1'b1;
    tick(1);
    stray_req = 1'b0;
    tick(3);
    model_result = 128'h44444444333333332222222211111111;
    push_wr(4'h8, 32'h4b5a6978, 1'b1, 1'b1);
    push_wr(4'h9, 32'h0f1e2d3c, 1'b1, 1'b1);
    push_wr(4'ha, 32'h76543210, 1'b1, 1'b1);
    push_wr(4'hb, 32'hfedcba98, 1'b1, 1'b1);
    bq.push_back(128'h44444444333333332222222211111111);
    bus_ready = 1'b0;
    send_block(128'hfedcba9876543210_0f1e2d3c4b5a6978, 1'b1);
    tick(5);
    bus_ready = 1'b1;
    drain("readback", 200);
    tick(3);

    // key expansion never completes
    model_key_ok = 1'b0;
    push_fips_key();
    eq.push_back(1);
    key_load(FIPS_KEY, 2'b00, 1'b0);
    cnt = 0;
    n = 0;
    while (!o_error && n < 6000) begin
      tick(1);
      n++;
      if (!o_error && !o_host_ready && !bus_data_valid) cnt++;
    end
    check("timeout_err_seen", o_error, 1'b1);
    check("timeout_cycles", cnt, 4096);
    check("timeout_idle", o_host_ready, 1'b1);
    check("timeout_not_loaded", o_key_loaded, 1'b0);
    drain("timeout_drain", 10);

    // reset in the middle of the data writes
    model_key_ok = 1'b1;
    push_fips_key();
    key_load(FIPS_KEY, 2'b00, 1'b0);
    drain("reload_key", 40);
    wait_loaded("reload_loaded", 40);
    tick(2);
    push_wr(4'h8, 32'hccddeeff, 1'b1, 1'b1);
    push_wr(4'h9, 32'h8899aabb, 1'b1, 1'b1);
    send_block(FIPS_PT, 1'b1);
    n = 0;
    while (!(bus_data_valid && bus_data_sel == 4'h9) && n < 20) begin
      tick(1);
      n++;
    end
    check("saw_sel9", {bus_data_valid, bus_data_sel}, {1'b1, 4'h9});
    #2 reset = 1'b0;
    #1;
    check("midrst_data_valid", bus_data_valid, 1'b0);
    check("midrst_host_ready", o_host_ready, 1'b1);
    check("midrst_key_loaded", o_key_loaded, 1'b0);
    check("midrst_block_valid", o_block_valid, 1'b0);
    check("midrst_queue", wq.size(), 0);
    tick(1);
    reset = 1'b1;
    tick(2);

    push_wr(4'h0, 32'h03020100, 1'b0, 1'b0);
    push_wr(4'h1, 32'h07060504, 1'b0, 1'b0);
    push_wr(4'h2, 32'h0b0a0908, 1'b0, 1'b0);
    push_wr(4'h3, 32'h0f0e0d0c, 1'b0, 1'b0);
    push_wr(4'h4, 32'h13121110, 1'b0, 1'b0);
    push_wr(4'h5, 32'h17161514, 1'b0, 1'b0);
    push_wr(4'h6, 32'h1b1a1918, 1'b0, 1'b0);
    push_wr(4'h7, 32'h1f1e1d1c, 1'b0, 1'b0);
    key_load(256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504_03020100, 2'b01, 1'b0);
    drain("post_rst_key", 40);
    wait_loaded("post_rst_loaded", 40);
    check("post_rst_key_mode", bus_key_mode, 2'b01);
    tick(10);
    drain("final", 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
